writeback: RTL
==============

Name: writeback

Overview:
- Final pipeline stage of the core. It takes the destination descriptor produced by decode (rd, wselector, fmode) and the execute/memory results.
- It sequences exactly one register-file write per instruction and returns the enable/done handshake.
- It drives the write ports of the integer (GPR) and float (FPR) register files, the opposite side of the read ports that decode samples.
- Memory loads may take several cycles; the stage waits for the memory unit's valid strobe.

Parameters:
- DATA_W, 32, register data width.
- REG_W, 5, register index width (32 registers per file).

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- enable  in  1  start pulse; sampled only in IDLE.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high in any state other than IDLE.
- rd  in  6  destination; rd[4:0] is the register index, rd[5] is ignored.
- wselector  in  2  source select: 00 no write, 01 ALU, 10 memory, 11 link.
- fmode  in  1  1 writes the FPR file, 0 writes the GPR file.
- alu_result  in  DATA_W  execute-stage result.
- link_data  in  DATA_W  return address (pc+1).
- mem_data  in  DATA_W  load data; valid only when mem_valid=1.
- mem_valid  in  1  load data strobe.
- gpr_we  out  1  GPR write enable.
- fpr_we  out  1  FPR write enable.
- w_addr  out  REG_W  write index.
- w_data  out  DATA_W  write data.

Behaviour:
- Reset (rstn=0 at posedge), all outputs:
  - state=IDLE.
  - done=0, busy=0, gpr_we=0, fpr_we=0, w_addr=0, w_data=0.
  - Internal latches cleared.
- Reset mid-operation aborts the instruction: no write is issued and no done pulse occurs.
- States are IDLE, WAIT_MEM and COMMIT.
- IDLE:
  - On enable=1, latch rd[4:0], wselector and fmode.
  - wselector 01 latches alu_result. wselector 11 latches link_data. All operands are sampled on that same edge.
  - wselector 10 goes to WAIT_MEM.
  - wselector 00, 01 and 11 go to COMMIT.
- WAIT_MEM:
  - On mem_valid=1, latch mem_data and go to COMMIT.
  - Otherwise hold with no bound; no timeout.
  - If mem_valid=1 on the same edge enable rises, the strobe is ignored; data is only accepted from the first edge after WAIT_MEM is entered.
- COMMIT: lasts exactly one cycle, then returns to IDLE.
  - done=1.
  - w_addr and w_data show the latched values.
  - fpr_we=1 if fmode=1 and wselector≠00.
  - gpr_we=1 if fmode=0, wselector≠00 and index≠0. GPR r0 is hardwired, so the write is suppressed but done is still pulsed.
  - FPR f0 is writable.
- gpr_we and fpr_we are never both 1, and each is high for at most one cycle per instruction.
- Latency from the enable edge to done:
  - 1 cycle for wselector 00, 01 and 11.
  - N+1 cycles for loads, where mem_valid is first sampled high N cycles after the enable edge.
- Pulses:
  - enable while busy=1, including during COMMIT, is ignored, and no second write occurs.
  - mem_valid in IDLE or COMMIT is ignored.
- Outside COMMIT:
  - w_addr and w_data hold their last committed values.
  - Both write enables are 0.
- Data is passed through unmodified; no width conversion is performed.

Test Plan:
1. ALU write: enable with rd=6'd5, wselector=01, fmode=0, alu_result=32'hDEADBEEF → next cycle gpr_we=1, w_addr=5, w_data=DEADBEEF, done=1; the following cycle gpr_we=0, done=0, busy=0.
2. Load with wait: enable with rd=6'd9, wselector=10, fmode=1; mem_valid=0 for 3 cycles, then 1 with mem_data=32'h3F800000 → busy stays 1 throughout; one cycle later fpr_we=1, w_addr=9, w_data=3F800000, done=1; gpr_we never asserted.
3. r0 and no-write cases:
   - enable with rd=0, wselector=01, fmode=0 → done=1 after 1 cycle, gpr_we=0.
   - Repeat with fmode=1 → fpr_we=1, w_addr=0.
   - wselector=00 with rd=7 → done=1, no write enable.
4. Link: enable with rd=6'd31, wselector=11, link_data=32'h00000124, alu_result=32'hFFFFFFFF → w_data=00000124 to GPR 31.
5. Protocol abuse and reset:
   - enable pulsed again during WAIT_MEM and during COMMIT → exactly one write and one done.
   - mem_valid pulsed in IDLE → no effect.
   - rstn=0 during WAIT_MEM, then mem_valid=1 → no write, no done, busy=0.

Source files
------------

// File: rtl/writeback_if.sv
// Writeback stage bus: destination descriptor, execute/memory results,
// handshake and register-file write ports.
interface writeback_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
);
  logic              enable;
  logic              done;
  logic              busy;
  logic [5:0]        rd;
  logic [1:0]        wselector;
  logic              fmode;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] link_data;
  logic [DATA_W-1:0] mem_data;
  logic              mem_valid;
  logic              gpr_we;
  logic              fpr_we;
  logic [REG_W-1:0]  w_addr;
  logic [DATA_W-1:0] w_data;

  modport master (
    output enable, rd, wselector, fmode, alu_result, link_data, mem_data, mem_valid,
    input  done, busy, gpr_we, fpr_we, w_addr, w_data
  );

  modport slave (
    input  enable, rd, wselector, fmode, alu_result, link_data, mem_data, mem_valid,
    output done, busy, gpr_we, fpr_we, w_addr, w_data
  );
endinterface

// File: rtl/writeback.sv
// Final pipeline stage: sequences one GPR/FPR write per instruction,
// waiting on the memory strobe for loads.
module writeback #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input logic        clk,
  input logic        rstn,
  writeback_if.slave wb
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    COMMIT
  } state_t;

  state_t            state_q, state_d;
  logic [REG_W-1:0]  addr_q, addr_d;
  logic [1:0]        sel_q, sel_d;
  logic              fmode_q, fmode_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [REG_W-1:0]  oaddr_q, oaddr_d;
  logic [DATA_W-1:0] odata_q, odata_d;

  logic unused_rd;
  assign unused_rd = ^wb.rd[5:REG_W];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sel_q   <= '0;
      fmode_q <= 1'b0;
      data_q  <= '0;
      oaddr_q <= '0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      fmode_q <= fmode_d;
      data_q  <= data_d;
      oaddr_q <= oaddr_d;
      odata_q <= odata_d;
    end
  end

  // Operand latches are refilled at enable, so the visible write port is
  // kept in a separate register that only updates on commit.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    fmode_d   = fmode_q;
    data_d    = data_q;
    oaddr_d   = oaddr_q;
    odata_d   = odata_q;
    wb.done   = 1'b0;
    wb.gpr_we = 1'b0;
    wb.fpr_we = 1'b0;
    wb.w_addr = oaddr_q;
    wb.w_data = odata_q;

    case (state_q)
      IDLE: begin
        if (wb.enable) begin
          addr_d  = wb.rd[REG_W-1:0];
          sel_d   = wb.wselector;
          fmode_d = wb.fmode;
          case (wb.wselector)
            2'b01:   data_d = wb.alu_result;
            2'b11:   data_d = wb.link_data;
            default: data_d = data_q;
          endcase
          state_d = (wb.wselector == 2'b10) ? WAIT_MEM : COMMIT;
        end
      end
      WAIT_MEM: begin
        if (wb.mem_valid) begin
          data_d  = wb.mem_data;
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        wb.done   = 1'b1;
        wb.w_addr = addr_q;
        wb.w_data = data_q;
        wb.fpr_we = fmode_q && (sel_q != 2'b00);
        // GPR r0 is hardwired to zero; FPR f0 is a real register.
        wb.gpr_we = !fmode_q && (sel_q != 2'b00) && (addr_q != '0);
        oaddr_d   = addr_q;
        odata_d   = data_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb.busy = (state_q != IDLE);

endmodule
